// File: rtl/soc2_timer_ctrl_if.sv
// Register request/ack bus between the core-side decoder and soc2_timer_ctrl.
// Single-cycle req; ack and rdata come back registered one cycle later.
interface soc2_timer_ctrl_if;
   logic        req;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/soc2_timer_ctrl.sv
// Prescaled up-counter timer with compare match, one-shot/periodic modes and a level irq.
// Programmed over a request/ack register port; EN is held as the IDLE/RUN state.
module soc2_timer_ctrl #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned PRE_W = 16
) (
   input  logic             clk,
   input  logic             resetn,
   soc2_timer_ctrl_if.slave bus,
   output logic             irq
);

   localparam logic [2:0] IdxCtrl     = 3'd0;
   localparam logic [2:0] IdxPrescale = 3'd1;
   localparam logic [2:0] IdxCount    = 3'd2;
   localparam logic [2:0] IdxCompare  = 3'd3;
   localparam logic [2:0] IdxStatus   = 3'd4;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e             state_q, state_d;
   logic               per_q, per_d;
   logic               ie_q, ie_d;
   logic [PRE_W-1:0]   div_q, div_d;
   logic [PRE_W-1:0]   pre_q, pre_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   cmp_q, cmp_d;
   logic               pend_q, pend_d;
   logic               ack_q;
   logic [31:0]        rdata_q, rdata_d;

   logic               en;
   logic               tick;
   logic               match;
   logic               wr;
   logic               rd;
   logic               reg_ok;
   logic [2:0]         reg_idx;
   logic               wr_ctrl;
   logic               wr_prescale;
   logic               wr_count;
   logic               wr_compare;
   logic               wr_status;

   // Address decode: only word-aligned offsets 0x00..0x10 hit a register.
   always_comb begin
      reg_idx = bus.addr[4:2];
      reg_ok  = (bus.addr[1:0] == 2'b00) && (bus.addr[4:2] <= IdxStatus);
   end

   assign wr          = bus.req & bus.we;
   assign rd          = bus.req & ~bus.we;
   assign wr_ctrl     = wr & reg_ok & (reg_idx == IdxCtrl);
   assign wr_prescale = wr & reg_ok & (reg_idx == IdxPrescale);
   assign wr_count    = wr & reg_ok & (reg_idx == IdxCount);
   assign wr_compare  = wr & reg_ok & (reg_idx == IdxCompare);
   assign wr_status   = wr & reg_ok & (reg_idx == IdxStatus);

   assign en    = (state_q == StRun);
   assign tick  = en & (pre_q == div_q);
   assign match = tick & (count_q == cmp_q);

   // EN lives in the FSM; a CTRL write outranks a one-shot auto-clear.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (wr_ctrl && bus.wdata[0]) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (wr_ctrl) begin
               state_d = bus.wdata[0] ? StRun : StIdle;
            end else if (match && !per_q) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      per_d = per_q;
      ie_d  = ie_q;
      div_d = div_q;
      cmp_d = cmp_q;
      if (wr_ctrl) begin
         per_d = bus.wdata[1];
         ie_d  = bus.wdata[2];
      end
      if (wr_prescale) begin
         div_d = bus.wdata[PRE_W-1:0];
      end
      if (wr_compare) begin
         cmp_d = bus.wdata[CNT_W-1:0];
      end
   end

   always_comb begin
      pre_d = pre_q + PRE_W'(1);
      if (!en || tick || wr_count) begin
         pre_d = '0;
      end
   end

   // A COUNT write outranks both increment and periodic reload.
   always_comb begin
      count_d = count_q;
      if (wr_count) begin
         count_d = bus.wdata[CNT_W-1:0];
      end else if (match) begin
         count_d = per_q ? '0 : count_q;
      end else if (tick) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   // Hardware set wins over a same-cycle W1C.
   assign pend_d = match | (pend_q & ~(wr_status & bus.wdata[0]));

   always_comb begin
      rdata_d = '0;
      if (rd && reg_ok) begin
         case (reg_idx)
            IdxCtrl:     rdata_d[2:0]       = {ie_q, per_q, en};
            IdxPrescale: rdata_d[PRE_W-1:0] = div_q;
            IdxCount:    rdata_d[CNT_W-1:0] = count_q;
            IdxCompare:  rdata_d[CNT_W-1:0] = cmp_q;
            IdxStatus:   rdata_d[0]         = pend_q;
            default:     rdata_d            = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         per_q   <= 1'b0;
         ie_q    <= 1'b0;
         div_q   <= '0;
         pre_q   <= '0;
         count_q <= '0;
         cmp_q   <= '0;
         pend_q  <= 1'b0;
         ack_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         per_q   <= per_d;
         ie_q    <= ie_d;
         div_q   <= div_d;
         pre_q   <= pre_d;
         count_q <= count_d;
         cmp_q   <= cmp_d;
         pend_q  <= pend_d;
         ack_q   <= bus.req;
         rdata_q <= rdata_d;
      end
   end

   assign bus.ack   = ack_q;
   assign bus.rdata = rdata_q;
   assign irq       = pend_q & ie_q;

endmodule
